// File: rtl/hs_tx_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : hs_tx_gen_if
// Description : Valid/ready link carrying DATA_W-bit words. The master
//               drives data/valid and the slave drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface hs_tx_gen_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] data;
   logic              valid;
   logic              ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/hs_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : hs_tx_gen
// Description : Valid/ready burst source. A start request in IDLE launches
//               num_beats words beginning at seed. Each word is held until
//               it is accepted. GAP idle cycles may follow every beat except
//               the last. done pulses once after the final handshake.
//               Optional macro HS_TX_LFSR_EN switches the word sequence from
//               increment to a 32-bit Galois LFSR (taps 0x80200003). That
//               build requires DATA_W = 32.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_tx_gen #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16,
   parameter int GAP    = 0
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              start,
   input  wire logic [CNT_W-1:0]  num_beats,
   input  wire logic [DATA_W-1:0] seed,
   hs_tx_gen_if.master            tx,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       beat_cnt
);

   // The gap counter holds GAP-1 down to 0. It keeps at least one bit so
   // that the declaration stays legal when GAP is 0 or 1.
   localparam int                GAP_CW   = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              valid_q, valid_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [CNT_W-1:0]  num_q,   num_d;
   logic [GAP_CW-1:0] gap_q,   gap_d;

`ifdef HS_TX_LFSR_EN
   function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] d);
      next_word = (d >> 1) ^ (d[0] ? DATA_W'(32'h8020_0003) : '0);
   endfunction

   // An all-zero LFSR state would lock up, so a zero seed is replaced.
   function automatic logic [DATA_W-1:0] first_word(input logic [DATA_W-1:0] s);
      first_word = (s == '0) ? DATA_W'(1) : s;
   endfunction
`else
   function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] d);
      next_word = d + DATA_W'(1);
   endfunction

   function automatic logic [DATA_W-1:0] first_word(input logic [DATA_W-1:0] s);
      first_word = s;
   endfunction
`endif

   // Next-state logic. All outputs are registered, so valid never depends
   // combinationally on ready.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      num_d   = num_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (start && (num_beats != '0)) begin
               num_d   = num_beats;
               data_d  = first_word(seed);
               valid_d = 1'b1;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (valid_q && tx.ready) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_d == num_q) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_FIN;
               end else if (GAP == 0) begin
                  data_d = next_word(data_q);
               end else begin
                  valid_d = 1'b0;
                  data_d  = next_word(data_q);
                  gap_d   = GAP_LOAD;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               valid_d = 1'b1;
               state_d = S_SEND;
            end else begin
               gap_d = gap_q - GAP_CW'(1);
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register. Reset abandons any burst in progress without done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         num_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         gap_q   <= gap_d;
      end
   end

   assign tx.data  = data_q;
   assign tx.valid = valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign beat_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_tx_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_hs_tx_gen
// Description : Directed vector bench for hs_tx_gen. One instance uses
//               back-to-back beats and the other uses GAP=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_tx_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Back-to-back instance (GAP = 0)
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] nb    = '0;
   logic [31:0] seed  = '0;
   logic        busy, done;
   logic [15:0] bcnt;
   hs_tx_gen_if #(.DATA_W(32)) tx0 ();

   // Gapped instance (GAP = 2)
   logic        rst_n_g = 1'b0;
   logic        start_g = 1'b0;
   logic [15:0] nb_g    = '0;
   logic [31:0] seed_g  = '0;
   logic        busy_g, done_g;
   logic [15:0] bcnt_g;
   hs_tx_gen_if #(.DATA_W(32)) txg ();

   hs_tx_gen #(.DATA_W(32), .CNT_W(16), .GAP(0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_beats(nb), .seed(seed),
      .tx(tx0.master), .busy(busy), .done(done), .beat_cnt(bcnt)
   );

   hs_tx_gen #(.DATA_W(32), .CNT_W(16), .GAP(2)) dut_g (
      .clk(clk), .rst_n(rst_n_g), .start(start_g), .num_beats(nb_g), .seed(seed_g),
      .tx(txg.master), .busy(busy_g), .done(done_g), .beat_cnt(bcnt_g)
   );

   typedef struct {
      logic        rst_n;
      logic        start;
      logic [15:0] nb;
      logic [31:0] seed;
      logic        ready;
      logic        e_valid;
      logic        chk_data;
      logic [31:0] e_data;
      logic        e_busy;
      logic        e_done;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vt[32];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic r, input logic s, input logic [15:0] n,
                               input logic [31:0] sd, input logic rdy, input logic ev,
                               input logic cd, input logic [31:0] ed, input logic eb,
                               input logic edn, input logic [15:0] ec);
      vec_t v;
      v.rst_n = r; v.start = s; v.nb = n; v.seed = sd; v.ready = rdy;
      v.e_valid = ev; v.chk_data = cd; v.e_data = ed;
      v.e_busy = eb; v.e_done = edn; v.e_cnt = ec;
      return v;
   endfunction

   // Watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tx0.ready = 1'b0;
      txg.ready = 1'b0;

      // Burst of 4 from 0x10 with ready held high
      vt[0]  = mk(0,0,0,32'h0,1,         0,1,32'h0,        0,0,0);
      vt[1]  = mk(1,1,4,32'h10,1,        1,1,32'h10,       1,0,0);
      vt[2]  = mk(1,0,4,32'h10,1,        1,1,32'h11,       1,0,1);
      vt[3]  = mk(1,0,4,32'h10,1,        1,1,32'h12,       1,0,2);
      vt[4]  = mk(1,0,4,32'h10,1,        1,1,32'h13,       1,0,3);
      vt[5]  = mk(1,0,0,32'h0,1,         0,0,32'h0,        1,1,4);
      // start in FIN, then start with num_beats=0 in IDLE: both ignored
      vt[6]  = mk(1,1,2,32'h77,1,        0,0,32'h0,        0,0,4);
      vt[7]  = mk(1,1,0,32'h88,1,        0,0,32'h0,        0,0,4);
      // Wrap burst, with start/num_beats/seed churn while busy
      vt[8]  = mk(1,1,3,32'hFFFFFFFE,0,  1,1,32'hFFFFFFFE, 1,0,0);
      vt[9]  = mk(1,1,7,32'h55,1,        1,1,32'hFFFFFFFF, 1,0,1);
      vt[10] = mk(1,1,7,32'h55,0,        1,1,32'hFFFFFFFF, 1,0,1);
      vt[11] = mk(1,0,0,32'h0,1,         1,1,32'h0,        1,0,2);
      vt[12] = mk(1,0,0,32'h0,0,         1,1,32'h0,        1,0,2);
      vt[13] = mk(1,0,0,32'h0,0,         1,1,32'h0,        1,0,2);
      vt[14] = mk(1,0,0,32'h0,1,         0,0,32'h0,        1,1,3);
      vt[15] = mk(1,0,0,32'h0,0,         0,0,32'h0,        0,0,3);
      // Ready toggling 1,0,0,1,0,1 with seed 0xA0
      vt[16] = mk(1,1,3,32'hA0,1,        1,1,32'hA0,       1,0,0);
      vt[17] = mk(1,0,0,32'h0,1,         1,1,32'hA1,       1,0,1);
      vt[18] = mk(1,0,0,32'h0,0,         1,1,32'hA1,       1,0,1);
      vt[19] = mk(1,0,0,32'h0,0,         1,1,32'hA1,       1,0,1);
      vt[20] = mk(1,0,0,32'h0,1,         1,1,32'hA2,       1,0,2);
      vt[21] = mk(1,0,0,32'h0,0,         1,1,32'hA2,       1,0,2);
      vt[22] = mk(1,0,0,32'h0,1,         0,0,32'h0,        1,1,3);
      vt[23] = mk(1,0,0,32'h0,0,         0,0,32'h0,        0,0,3);
      // Reset after 2 of 5 beats, then a fresh burst
      vt[24] = mk(1,1,5,32'h200,1,       1,1,32'h200,      1,0,0);
      vt[25] = mk(1,0,0,32'h0,1,         1,1,32'h201,      1,0,1);
      vt[26] = mk(1,0,0,32'h0,1,         1,1,32'h202,      1,0,2);
      vt[27] = mk(0,0,0,32'h0,1,         0,1,32'h0,        0,0,0);
      vt[28] = mk(1,1,2,32'h300,1,       1,1,32'h300,      1,0,0);
      vt[29] = mk(1,0,0,32'h0,1,         1,1,32'h301,      1,0,1);
      vt[30] = mk(1,0,0,32'h0,1,         0,0,32'h0,        1,1,2);
      vt[31] = mk(1,0,0,32'h0,1,         0,0,32'h0,        0,0,2);

      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         rst_n     = vt[i].rst_n;
         start     = vt[i].start;
         nb        = vt[i].nb;
         seed      = vt[i].seed;
         tx0.ready = vt[i].ready;
         @(posedge clk);
         #1;
         n_vec++;
         if (tx0.valid !== vt[i].e_valid) begin
            n_err++;
            $display("FAIL vec%0d valid: got %b want %b", i, tx0.valid, vt[i].e_valid);
         end
         if (vt[i].chk_data && (tx0.data !== vt[i].e_data)) begin
            n_err++;
            $display("FAIL vec%0d data: got %h want %h", i, tx0.data, vt[i].e_data);
         end
         if (busy !== vt[i].e_busy) begin
            n_err++;
            $display("FAIL vec%0d busy: got %b want %b", i, busy, vt[i].e_busy);
         end
         if (done !== vt[i].e_done) begin
            n_err++;
            $display("FAIL vec%0d done: got %b want %b", i, done, vt[i].e_done);
         end
         if (bcnt !== vt[i].e_cnt) begin
            n_err++;
            $display("FAIL vec%0d beat_cnt: got %0d want %0d", i, bcnt, vt[i].e_cnt);
         end
      end

      // Gapped instance: GAP=2, ready=1, 3 beats from 0x40.
      // Expected valid 1,0,0,1,0,0,1 then the FIN cycle and back to idle.
      begin
         logic        gv [9] = '{1,0,0,1,0,0,1,0,0};
         logic [31:0] gd [9] = '{32'h40,32'h41,32'h41,32'h41,32'h42,32'h42,32'h42,32'h42,32'h42};
         logic        gdn[9] = '{0,0,0,0,0,0,0,1,0};
         logic        gb [9] = '{1,1,1,1,1,1,1,1,0};
         logic [15:0] gc [9] = '{0,1,1,1,2,2,2,3,3};
         @(negedge clk);
         rst_n_g   = 1'b0;
         @(negedge clk);
         rst_n_g   = 1'b1;
         start_g   = 1'b1;
         nb_g      = 16'd3;
         seed_g    = 32'h40;
         txg.ready = 1'b1;
         for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (txg.valid !== gv[k]) begin
               n_err++;
               $display("FAIL gap%0d valid: got %b want %b", k, txg.valid, gv[k]);
            end
            if (txg.data !== gd[k]) begin
               n_err++;
               $display("FAIL gap%0d data: got %h want %h", k, txg.data, gd[k]);
            end
            if (done_g !== gdn[k]) begin
               n_err++;
               $display("FAIL gap%0d done: got %b want %b", k, done_g, gdn[k]);
            end
            if (busy_g !== gb[k]) begin
               n_err++;
               $display("FAIL gap%0d busy: got %b want %b", k, busy_g, gb[k]);
            end
            if (bcnt_g !== gc[k]) begin
               n_err++;
               $display("FAIL gap%0d beat_cnt: got %0d want %0d", k, bcnt_g, gc[k]);
            end
            @(negedge clk);
            start_g = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
